centroid_grouper: RTL and testbench

CENTROID_GROUPER -- requirements
Module: centroid_grouper

---
 rtl/centroid_grouper.sv | 200 ++++++++++++++++++++
 tb/tb_centroid_grouper.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/centroid_grouper.sv
// Groups runs of nearby samples inside a selection window and queues each group's
// sum and member count for a downstream consumer; also gates a downstream clock divider.
module centroid_grouper #(
  parameter int DATA_W     = 40,
  parameter int CNT_W      = 10,
  parameter int THRESH     = 4000,
  parameter int MIN_GROUP  = 3,
  parameter int WARMUP     = 40,
  parameter int HOLDOFF    = 40,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk_200MHz_i,
  input  logic                    reset,
  input  logic                    start_selection,
  input  logic [DATA_W-1:0]       sample_in,
  input  logic                    sample_valid,
  output logic [DATA_W+CNT_W-1:0] grp_sum,
  output logic [CNT_W-1:0]        grp_size,
  output logic                    grp_valid,
  input  logic                    grp_ready,
  output logic                    enable_clk_div,
  output logic                    drop_o,
  output logic [7:0]              drop_cnt
);

  localparam int SUM_W = DATA_W + CNT_W;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic signed [DATA_W:0] THR_P = (DATA_W+1)'(THRESH);
  localparam logic signed [DATA_W:0] THR_N = -THR_P;
  localparam logic [15:0] WARM_LAST = 16'(WARMUP - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF - 1);

  typedef enum logic [2:0] {S_IDLE, S_WARMUP, S_ACTIVE, S_FLUSH, S_HOLDOFF} state_t;

  state_t             state_q;
  logic [15:0]        timer_q;
  logic               en_q;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  prev_q, prev_d;
  logic               has_prev_q, has_prev_d;
  logic               drop_q;
  logic [7:0]         drop_cnt_q;

  logic               push_req;
  logic [SUM_W-1:0]   push_sum;
  logic [CNT_W-1:0]   push_size;
  logic signed [DATA_W:0] diff;
  logic               is_match, big_enough;
  logic [SUM_W-1:0]   grow_sum;
  logic [CNT_W-1:0]   grow_cnt;

  logic [SUM_W+CNT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        fill_q;
  logic               full, pop, wr_en, drop;

  // Group accumulation: decides what this cycle's sample does to the open group.
  always_comb begin
    diff       = $signed({1'b0, sample_in}) - $signed({1'b0, prev_q});
    is_match   = (diff < THR_P) && (diff > THR_N);
    big_enough = count_q >= CNT_W'(MIN_GROUP);
    grow_sum   = (count_q == '0) ? SUM_W'(prev_q) + SUM_W'(sample_in) : sum_q + SUM_W'(sample_in);
    grow_cnt   = (count_q == '0) ? CNT_W'(2) : count_q + CNT_W'(1);
    push_req   = 1'b0;
    push_sum   = sum_q;
    push_size  = count_q;
    sum_d      = sum_q;
    count_d    = count_q;
    prev_d     = prev_q;
    has_prev_d = has_prev_q;
    case (state_q)
      S_ACTIVE: begin
        if (start_selection && sample_valid) begin
          prev_d     = sample_in;
          has_prev_d = 1'b1;
          if (has_prev_q) begin
            if (is_match) begin
              if (grow_cnt == '1) begin
                // Counter would overflow next time: emit now and start fresh.
                push_req  = 1'b1;
                push_sum  = grow_sum;
                push_size = grow_cnt;
                sum_d     = '0;
                count_d   = '0;
              end else begin
                sum_d   = grow_sum;
                count_d = grow_cnt;
              end
            end else begin
              push_req = big_enough;
              sum_d    = '0;
              count_d  = '0;
            end
          end
        end
      end
      S_FLUSH: begin
        push_req   = big_enough;
        sum_d      = '0;
        count_d    = '0;
        prev_d     = '0;
        has_prev_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign full      = fill_q == (AW+1)'(FIFO_DEPTH);
  assign grp_valid = fill_q != '0;
  assign pop       = grp_valid && grp_ready;
  assign wr_en     = push_req && (!full || pop) && !reset;
  assign drop      = push_req && full && !pop;

  always_ff @(posedge clk_200MHz_i) begin
    if (wr_en) mem[wr_ptr_q] <= {push_size, push_sum};
  end

  assign grp_sum        = grp_valid ? mem[rd_ptr_q][SUM_W-1:0] : '0;
  assign grp_size       = grp_valid ? mem[rd_ptr_q][SUM_W+CNT_W-1:SUM_W] : '0;
  assign enable_clk_div = en_q;
  assign drop_o         = drop_q;
  assign drop_cnt       = drop_cnt_q;

  always_ff @(posedge clk_200MHz_i) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      en_q       <= 1'b0;
      sum_q      <= '0;
      count_q    <= '0;
      prev_q     <= '0;
      has_prev_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      sum_q      <= sum_d;
      count_q    <= count_d;
      prev_q     <= prev_d;
      has_prev_q <= has_prev_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   fill_q <= fill_q + (AW+1)'(1);
        2'b01:   fill_q <= fill_q - (AW+1)'(1);
        default: ;
      endcase
      drop_q <= drop;
      if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;

      case (state_q)
        S_IDLE: begin
          if (start_selection) begin
            state_q <= S_WARMUP;
            timer_q <= '0;
            en_q    <= 1'b1;
          end
        end
        S_WARMUP: begin
          if (!start_selection) begin
            state_q <= S_HOLDOFF;
            timer_q <= '0;
          end else if (timer_q == WARM_LAST) begin
            state_q <= S_ACTIVE;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        S_ACTIVE: begin
          if (!start_selection) state_q <= S_FLUSH;
        end
        S_FLUSH: begin
          state_q <= S_HOLDOFF;
          timer_q <= '0;
        end
        S_HOLDOFF: begin
          // The holdoff interval only starts once the consumer has drained the queue.
          if (start_selection) begin
            state_q <= S_WARMUP;
            timer_q <= '0;
            en_q    <= 1'b1;
          end else if (grp_valid) begin
            timer_q <= '0;
          end else if (timer_q == HOLD_LAST) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_centroid_grouper.sv
// Directed bench for centroid_grouper: linear stimulus with hand-computed expectations.
module tb_centroid_grouper;
  localparam int DATA_W = 40;
  localparam int CNT_W  = 10;

  logic                    clk_200MHz_i = 1'b0;
  logic                    reset = 1'b1;
  logic                    start_selection = 1'b0;
  logic [DATA_W-1:0]       sample_in = '0;
  logic                    sample_valid = 1'b0;
  logic [DATA_W+CNT_W-1:0] grp_sum;
  logic [CNT_W-1:0]        grp_size;
  logic                    grp_valid;
  logic                    grp_ready = 1'b0;
  logic                    enable_clk_div;
  logic                    drop_o;
  logic [7:0]              drop_cnt;

  int checks = 0;
  int errors = 0;

  centroid_grouper dut (
    .clk_200MHz_i   (clk_200MHz_i),
    .reset          (reset),
    .start_selection(start_selection),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .grp_sum        (grp_sum),
    .grp_size       (grp_size),
    .grp_valid      (grp_valid),
    .grp_ready      (grp_ready),
    .enable_clk_div (enable_clk_div),
    .drop_o         (drop_o),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk_200MHz_i = ~clk_200MHz_i;

  task automatic step();
    @(posedge clk_200MHz_i);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic pop_one();
    grp_ready = 1'b1;
    step();
    grp_ready = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [63:0] size, input logic [63:0] sum);
    check({tag, "_valid"}, 64'(grp_valid), 64'd1);
    check({tag, "_size"}, 64'(grp_size), size);
    check({tag, "_sum"}, 64'(grp_sum), sum);
  endtask

  initial begin
    // Reset state
    step(); step();
    check("rst_valid", 64'(grp_valid), 0);
    check("rst_sum", 64'(grp_sum), 0);
    check("rst_size", 64'(grp_size), 0);
    check("rst_en", 64'(enable_clk_div), 0);
    check("rst_drop", 64'(drop_o), 0);
    check("rst_dropcnt", 64'(drop_cnt), 0);
    reset = 1'b0;
    step();
    check("idle_en", 64'(enable_clk_div), 0);

    // Window opens; a sample on the last warmup cycle must be ignored
    start_selection = 1'b1;
    step();
    check("warm_en", 64'(enable_clk_div), 1);
    repeat (39) step();
    send(1200);

    // Basic group: 1000..2500 then 20000
    send(1000); send(1500); send(2000); send(2500);
    check("grpA_pre", 64'(grp_valid), 0);
    send(20000);
    check_head("grpA", 4, 7000);
    pop_one();
    check("grpA_popped", 64'(grp_valid), 0);
    check("empty_sum", 64'(grp_sum), 0);

    // Too-small group is discarded
    send(1000); send(1500); send(9000);
    check("small_nopush", 64'(grp_valid), 0);

    // Diff exactly +4000 terminates
    send(9000); send(9000); send(13000);
    check_head("d4000", 3, 27000);
    pop_one();

    // Diffs +3999 / -3999 join
    send(16999); send(13000); send(9001); send(13001);
    check_head("d3999", 4, 52000);
    pop_one();

    // Diff exactly -4000 terminates
    send(9001); send(9001); send(9001); send(5001);
    check_head("dm4000", 3, 27003);
    pop_one();

    // Five groups with no consumer: fifth one dropped
    send(100000);
    for (int g = 1; g <= 5; g++) begin
      send(100000 * g); send(100000 * g);
      send(100000 * (g + 1));
      if (g == 4) check("no_drop_g4", 64'(drop_o), 0);
    end
    check("drop_pulse", 64'(drop_o), 1);
    check("drop_cnt1", 64'(drop_cnt), 1);
    step();
    check("drop_one_cycle", 64'(drop_o), 0);
    check_head("full_head", 3, 300000);

    // Push and pop together while full
    send(600000); send(600000);
    grp_ready = 1'b1;
    send(700000);
    grp_ready = 1'b0;
    check("fullpp_drop", 64'(drop_o), 0);
    check("fullpp_cnt", 64'(drop_cnt), 1);
    check_head("q1", 3, 600000);
    pop_one();
    check_head("q2", 3, 900000);
    pop_one();
    check_head("q3", 3, 1200000);
    pop_one();
    check_head("q4", 3, 1800000);
    pop_one();
    check("q_empty", 64'(grp_valid), 0);

    // Window closes with open size-3 group: flush, then holdoff after the pop
    send(700000); send(700000);
    start_selection = 1'b0;
    step();
    step();
    check_head("flush", 3, 2100000);
    repeat (5) step();
    check("hold_wait_en", 64'(enable_clk_div), 1);
    pop_one();
    repeat (39) step();
    check("hold_en_hi", 64'(enable_clk_div), 1);
    step();
    check("hold_en_lo", 64'(enable_clk_div), 0);

    // Counter saturation pushes at 1023 members
    start_selection = 1'b1;
    step();
    repeat (40) step();
    send(7000);
    repeat (1021) send(7000);
    check("sat_pre", 64'(grp_valid), 0);
    send(7000);
    check_head("sat", 1023, 7161000);
    pop_one();

    // Reset mid-group at count 5
    send(7000); send(7000); send(7000); send(7000);
    reset = 1'b1;
    step();
    check("mid_rst_valid", 64'(grp_valid), 0);
    check("mid_rst_sum", 64'(grp_sum), 0);
    check("mid_rst_size", 64'(grp_size), 0);
    check("mid_rst_en", 64'(enable_clk_div), 0);
    check("mid_rst_drop", 64'(drop_o), 0);
    check("mid_rst_dropcnt", 64'(drop_cnt), 0);
    reset = 1'b0;
    step();
    check("post_rst_valid", 64'(grp_valid), 0);
    check("post_rst_drop", 64'(drop_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
